softmax_ctrl: RTL and testbench
===============================

Name: softmax_ctrl

Overview:
- Sequencer for one 65-class softmax pass around the exp/adder-tree datapath and a downstream divider.
- Accepts a packed 65×8-bit score vector and issues it once to the adder tree. Waits for the 24-bit exp-sum, then streams 65 numerator/denominator pairs to the divider.
- Owns the tree's pipeline-enable, handles timeout and flush of the tree pipeline, and reports completion status.

Parameters:
- N_CLASS, 65, classes per vector (fixed width of tree interface).
- DW, 8, bits per class score.
- SUM_W, 24, exp-sum width.
- TREE_LAT, 7, adder-tree latency in enabled cycles, from in_valid sample to out_valid.
- TIMEOUT, 15, max WAIT cycles before abort (must be > TREE_LAT).

Ports:
- aclk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  N_CLASS*DW  score vector; class i at bits [i*DW+DW-1 : i*DW].
- in_valid  in  1  vector offered.
- in_ready  out  1  controller can accept a vector.
- tree_data  out  N_CLASS*DW  buffered vector to adder tree.
- tree_in_valid  out  1  one-cycle issue strobe to tree.
- tree_en  out  1  tree pipeline advance enable (tree's stall input).
- tree_sum  in  SUM_W  exp-sum from tree.
- tree_out_valid  in  1  tree_sum valid.
- div_num  out  16  exp numerator for current class.
- div_den  out  SUM_W  latched exp-sum.
- div_idx  out  7  current class index 0..N_CLASS-1.
- div_last  out  1  high with div_valid when div_idx == N_CLASS-1.
- div_valid  out  1  divider request.
- div_ready  in  1  divider accepts.
- done  out  1  one-cycle pulse at end of pass (normal or abort).
- err_timeout  out  1  status: last pass aborted by timeout.
- zero_sum  out  1  status: last pass had sum==0, no divisions issued.

Behaviour:
- Reset: state IDLE, all outputs 0 except in_ready = 1 from the first cycle after rst drops. Buffer, sum, index and counters are cleared. Reset mid-pass abandons the pass with no done pulse.
- States: IDLE, ISSUE, WAIT, DIV, FLUSH, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready, capture in_data into the buffer, clear err_timeout and zero_sum, go to ISSUE. No other state asserts in_ready.
- ISSUE (1 cycle): tree_in_valid = 1, tree_en = 1, tree_data = buffer (held stable in all states). Clear the wait counter. Go to WAIT.
- WAIT:
  - tree_en = 1; the counter increments each cycle.
  - On tree_out_valid: latch tree_sum into div_den. If sum == 0, set zero_sum and go to DONE; otherwise set div_idx = 0 and go to DIV.
  - If the counter reaches TIMEOUT without tree_out_valid: set err_timeout and go to FLUSH.
  - Nominal: vector accepted at cycle T, tree_in_valid at T+1, tree_out_valid at T+8.
- FLUSH: tree_en = 1, tree_in_valid = 0 for TREE_LAT cycles to drain stray valids, then go to DONE.
- tree_en = 0 in IDLE, DIV and DONE (tree frozen). tree_out_valid outside WAIT is ignored.
- DIV:
  - div_valid = 1. div_num = exp(buffer[div_idx]).
  - div_num, div_den, div_idx and div_last are held stable while div_valid & !div_ready.
  - On handshake: div_idx increments. The handshake with div_last goes to DONE.
  - Exactly N_CLASS beats per pass, in index order 0..64.
- exp rule (bit-exact with tree): c = 8'h07 − score, 8-bit wrap, signed. If c[7] = 1, num = 16'hFFFF; else num = 16'h8000 >> c (shift ≥ 16 gives 0).
- DONE (1 cycle): done = 1, then IDLE. err_timeout and zero_sum hold until the next accept.

Test Plan:
- All scores 0x07 → tree_in_valid one cycle after accept. Model returns sum 0x208000 after 7 cycles. Expect 65 beats with div_num = 0x8000, div_den = 0x208000, div_last only at idx 64, then done, in_ready high again.
- Scores: class0 = 0x08, class1 = 0xFF, class2 = 0x87, rest 0x07 → div_num 0xFFFF, 0x0080, 0xFFFF, then 0x8000 for the rest.
- div_ready random 30% duty → outputs stable during stall. No beat lost or duplicated. Index sequence 0..64 exact.
- All scores 0x90 (c = 119 → 0), model sum 0 → zero_sum = 1, zero div_valid cycles, done pulse.
- Model never asserts tree_out_valid → err_timeout at the 15th WAIT cycle. tree_en held 7 more cycles, then done. Next vector completes normally.
- rst asserted during DIV at idx 20 → next cycle all outputs 0, no done. in_ready = 1 after release. Following pass correct.

Source files
------------

// File: rtl/softmax_ctrl.sv
// Sequencer for one softmax pass: issues a score vector to the exp/adder tree,
// waits for the exp-sum, then streams numerator/denominator pairs to a divider.
module softmax_ctrl #(
  parameter int N_CLASS  = 65,
  parameter int DW       = 8,
  parameter int SUM_W    = 24,
  parameter int TREE_LAT = 7,
  parameter int TIMEOUT  = 15
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic [N_CLASS*DW-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CLASS*DW-1:0] tree_data,
  output logic                  tree_in_valid,
  output logic                  tree_en,
  input  logic [SUM_W-1:0]      tree_sum,
  input  logic                  tree_out_valid,
  output logic [15:0]           div_num,
  output logic [SUM_W-1:0]      div_den,
  output logic [6:0]            div_idx,
  output logic                  div_last,
  output logic                  div_valid,
  input  logic                  div_ready,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  zero_sum
);

  localparam int CW = $clog2(TIMEOUT + TREE_LAT + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] FL_LAST  = CW'(TREE_LAT - 1);
  localparam logic [6:0]    IDX_LAST = 7'(N_CLASS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DIV, S_FLUSH, S_DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [N_CLASS*DW-1:0]   vec_q;
  logic [6:0]              idx_nxt;

  // Bit-exact with the tree's exp: negative exponent saturates to full scale.
  function automatic logic [15:0] exp_num(input logic [DW-1:0] score);
    logic signed [DW-1:0] c;
    c = $signed(DW'(7) - score);
    if (c[DW-1])
      return 16'hFFFF;
    else
      return 16'h8000 >> c;
  endfunction

  function automatic logic [DW-1:0] score_at(input logic [N_CLASS*DW-1:0] v,
                                             input logic [6:0] idx);
    return v[int'(idx)*DW +: DW];
  endfunction

  assign idx_nxt   = div_idx + 7'd1;
  assign tree_data = vec_q;
  // Combinational so the controller is ready in the very first cycle after reset.
  assign in_ready  = (state == S_IDLE) && !rst;

  always_ff @(posedge aclk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      vec_q         <= '0;
      tree_in_valid <= 1'b0;
      tree_en       <= 1'b0;
      div_num       <= '0;
      div_den       <= '0;
      div_idx       <= '0;
      div_last      <= 1'b0;
      div_valid     <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      zero_sum      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            vec_q         <= in_data;
            err_timeout   <= 1'b0;
            zero_sum      <= 1'b0;
            tree_in_valid <= 1'b1;
            tree_en       <= 1'b1;
            state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tree_in_valid <= 1'b0;
          cnt           <= '0;
          state         <= S_WAIT;
        end
        // WAIT: a late tree_out_valid on the timeout cycle still wins.
        S_WAIT: begin
          if (tree_out_valid) begin
            div_den <= tree_sum;
            tree_en <= 1'b0;
            if (tree_sum == '0) begin
              zero_sum <= 1'b1;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              div_idx   <= '0;
              div_num   <= exp_num(score_at(vec_q, 7'd0));
              div_last  <= (IDX_LAST == 7'd0);
              div_valid <= 1'b1;
              state     <= S_DIV;
            end
          end else if (cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= S_FLUSH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (cnt == FL_LAST) begin
            tree_en <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DIV: begin
          if (div_ready) begin
            if (div_last) begin
              div_valid <= 1'b0;
              div_last  <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              div_idx  <= idx_nxt;
              div_num  <= exp_num(score_at(vec_q, idx_nxt));
              div_last <= (idx_nxt == IDX_LAST);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_ctrl.sv
// Table-driven bench for softmax_ctrl with a behavioural adder-tree pipeline model.
module tb_softmax_ctrl;

  logic          aclk = 1'b0;
  logic          rst;
  logic [519:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [519:0]  tree_data;
  logic          tree_in_valid;
  logic          tree_en;
  logic [23:0]   tree_sum;
  logic          tree_out_valid;
  logic [15:0]   div_num;
  logic [23:0]   div_den;
  logic [6:0]    div_idx;
  logic          div_last;
  logic          div_valid;
  logic          div_ready;
  logic          done;
  logic          err_timeout;
  logic          zero_sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 aclk = ~aclk;

  softmax_ctrl dut (
    .aclk(aclk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tree_data(tree_data), .tree_in_valid(tree_in_valid), .tree_en(tree_en),
    .tree_sum(tree_sum), .tree_out_valid(tree_out_valid),
    .div_num(div_num), .div_den(div_den), .div_idx(div_idx), .div_last(div_last),
    .div_valid(div_valid), .div_ready(div_ready),
    .done(done), .err_timeout(err_timeout), .zero_sum(zero_sum)
  );

  // Adder-tree model: 7-stage valid pipe advancing only while tree_en is high.
  logic        model_on  = 1'b1;
  logic [23:0] model_sum = '0;
  logic [6:0]  sr        = '0;
  always_ff @(posedge aclk)
    if (tree_en) sr <= {sr[5:0], tree_in_valid & model_on};
  assign tree_out_valid = sr[6];
  assign tree_sum       = model_sum;

  typedef struct {
    logic [7:0]  base, s0, s1, s2;
    logic [23:0] sum;
    bit          model_on;
    int          duty;
    logic [15:0] n0, n1, n2, nr;
    int          beats, first_valid, first_err, done_k, en_cnt;
    bit          err, zs;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [7:0] base, s0, s1, s2, input logic [23:0] sum,
                              input bit on, input int duty,
                              input logic [15:0] n0, n1, n2, nr,
                              input int beats, fv, fe, dk, en, input bit err, zs);
    vec_t v;
    v.base = base; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.sum = sum;
    v.model_on = on; v.duty = duty;
    v.n0 = n0; v.n1 = n1; v.n2 = n2; v.nr = nr;
    v.beats = beats; v.first_valid = fv; v.first_err = fe; v.done_k = dk; v.en_cnt = en;
    v.err = err; v.zs = zs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic run_pass(input int vi);
    vec_t        v;
    logic [519:0] d;
    int          k, beat, first_valid, first_err, done_k, en_cnt, tiv;
    bit          pv, rdy;
    logic [15:0] p_num, exp_n;
    logic [23:0] p_den;
    logic [6:0]  p_idx;
    logic        p_last;
    string       tag;
    v = vecs[vi];
    tag = $sformatf("v%0d", vi);
    for (int i = 0; i < 65; i++)
      d[i*8 +: 8] = (i == 0) ? v.s0 : (i == 1) ? v.s1 : (i == 2) ? v.s2 : v.base;
    model_on  = v.model_on;
    model_sum = v.sum;
    chk({tag, " in_ready_idle"}, in_ready, 1);
    in_data = d; in_valid = 1'b1;
    @(posedge aclk); #1;
    in_valid = 1'b0;
    chk({tag, " issue_strobe"}, tree_in_valid, 1);
    chk({tag, " tree_data"}, 64'(tree_data != d), 0);
    chk({tag, " in_ready_busy"}, in_ready, 0);
    k = 0; beat = 0; first_valid = -1; first_err = -1; done_k = -1; en_cnt = 0; tiv = 0;
    while (k < 2000) begin
      if (tree_en) en_cnt++;
      if (k > 0 && tree_in_valid) tiv++;
      if (div_valid && first_valid < 0) first_valid = k;
      if (err_timeout && first_err < 0) first_err = k;
      if (done) begin
        done_k = k;
        break;
      end
      rdy = ($urandom_range(0, 99) < v.duty);
      div_ready = rdy;
      pv = div_valid; p_num = div_num; p_den = div_den; p_idx = div_idx; p_last = div_last;
      @(posedge aclk); #1;
      k++;
      if (pv && rdy) begin
        exp_n = (beat == 0) ? v.n0 : (beat == 1) ? v.n1 : (beat == 2) ? v.n2 : v.nr;
        chk($sformatf("%s idx@%0d", tag, beat), p_idx, beat);
        chk($sformatf("%s num@%0d", tag, beat), p_num, exp_n);
        chk($sformatf("%s den@%0d", tag, beat), p_den, v.sum);
        chk($sformatf("%s last@%0d", tag, beat), p_last, beat == 64);
        beat++;
      end else if (pv) begin
        chk($sformatf("%s stall@%0d", tag, beat),
            {div_valid, div_num, div_den, div_idx, div_last},
            {1'b1, p_num, p_den, p_idx, p_last});
      end
    end
    div_ready = 1'b0;
    chk({tag, " done_seen"}, done_k >= 0, 1);
    if (v.done_k >= 0) chk({tag, " done_lat"}, done_k, v.done_k);
    chk({tag, " beats"}, beat, v.beats);
    chk({tag, " first_valid"}, first_valid, v.first_valid);
    chk({tag, " first_err"}, first_err, v.first_err);
    chk({tag, " tree_en_cycles"}, en_cnt, v.en_cnt);
    chk({tag, " extra_issue"}, tiv, 0);
    chk({tag, " err_timeout"}, err_timeout, v.err);
    chk({tag, " zero_sum"}, zero_sum, v.zs);
    @(posedge aclk); #1;
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " in_ready_after"}, in_ready, 1);
    chk({tag, " err_hold"}, err_timeout, v.err);
    chk({tag, " zs_hold"}, zero_sum, v.zs);
  endtask

  initial begin
    int w;
    vecs[0] = mk(8'h07, 8'h07, 8'h07, 8'h07, 24'h208000, 1, 100,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 65, 8, -1, 73, 8, 0, 0);
    vecs[1] = mk(8'h07, 8'h08, 8'hFF, 8'h87, 24'h1234AB, 1, 100,
                 16'hFFFF, 16'h0080, 16'hFFFF, 16'h8000, 65, 8, -1, 73, 8, 0, 0);
    vecs[2] = mk(8'h07, 8'h07, 8'h07, 8'h07, 24'h208000, 1, 30,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 65, 8, -1, -1, 8, 0, 0);
    vecs[3] = mk(8'h90, 8'h90, 8'h90, 8'h90, 24'h000000, 1, 100,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, -1, -1, 8, 8, 0, 1);
    vecs[4] = mk(8'h07, 8'h07, 8'h07, 8'h07, 24'h000005, 0, 100,
                 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, -1, 16, 23, 23, 1, 0);
    vecs[5] = mk(8'h80, 8'h00, 8'h7F, 8'h06, 24'hFFFFFF, 1, 60,
                 16'h0100, 16'hFFFF, 16'h4000, 16'hFFFF, 65, 8, -1, -1, 8, 0, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; div_ready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", 64'({tree_data, tree_in_valid, tree_en, div_num, div_den, div_idx,
                              div_last, div_valid, done, err_timeout, zero_sum} != '0), 0);
    chk("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) run_pass(i);

    // Reset in the middle of the DIV stream at index 20.
    model_on = 1'b1; model_sum = 24'h208000;
    in_data = {65{8'h07}}; in_valid = 1'b1;
    @(posedge aclk); #1;
    in_valid = 1'b0; div_ready = 1'b1;
    w = 0;
    while (!(div_valid && div_idx == 7'd20) && w < 200) begin
      @(posedge aclk); #1;
      w++;
    end
    chk("reach_idx20", w < 200, 1);
    rst = 1'b1; div_ready = 1'b0;
    @(posedge aclk); #1;
    chk("midreset_outputs", 64'({tree_in_valid, tree_en, div_num, div_den, div_idx,
                                 div_last, div_valid, done, err_timeout, zero_sum} != '0), 0);
    chk("midreset_tree_data", 64'(tree_data != '0), 0);
    chk("midreset_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("midreset_release_ready", in_ready, 1);
    @(posedge aclk); #1;
    chk("midreset_no_done", done, 0);
    run_pass(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
